// File: rtl/cpu_dmem_ctrl_pkg.sv
// Shared types for the data-memory controller: FSM states, lane count, error causes.
// Optional parity checking is enabled with DMEM_PARITY_EN.
package cpu_dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int unsigned ERR_W = 4;

  localparam logic [ERR_W-1:0] ERR_NONE     = 4'b0000;
  localparam logic [ERR_W-1:0] ERR_CONFLICT = 4'b0001;
  localparam logic [ERR_W-1:0] ERR_MISALIGN = 4'b0010;
  localparam logic [ERR_W-1:0] ERR_RANGE    = 4'b0100;
  localparam logic [ERR_W-1:0] ERR_PARITY   = 4'b1000;

  function automatic int unsigned lanes(input int unsigned w);
    return w / 8;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word storage, synchronous write and combinational read.
// With DMEM_PARITY_EN one even-parity bit is kept per byte lane.
module dmem_array
  import cpu_dmem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                       clk,
  input  logic                       wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]   idx_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [lanes(DATA_W)-1:0]   be_i,
`ifdef DMEM_PARITY_EN
  output logic                       perr_o,
`endif
  output logic [DATA_W-1:0]          rdata_o
);

  localparam int unsigned NB = lanes(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int l = 0; l < NB; l++) begin
        if (be_i[l]) mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int l = 0; l < NB; l++) begin
        if (be_i[l]) par_q[idx_i][l] <= ^wdata_i[8*l +: 8];
      end
    end
  end

  // any lane whose stored parity disagrees with its data flags the word
  always_comb begin
    perr_o = 1'b0;
    for (int l = 0; l < NB; l++) begin
      if ((^rdata_o[8*l +: 8]) != par_q[idx_i][l]) perr_o = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/cpu_dmem_ctrl.sv
// Data-memory controller: request latch, wait-state FSM, error reporting.
// Define DMEM_PARITY_EN to add per-lane parity checking on loads.
module cpu_dmem_ctrl
  import cpu_dmem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W/8-1:0]      mem_be,
  input  logic                     mem_we,
  input  logic                     mem_re,
  output logic [DATA_W-1:0]        mem_rdata,
  output logic                     mem_ready,
  output logic                     mem_err,
  output logic                     busy
);

  localparam int unsigned NB    = lanes(DATA_W);
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(NB - 1);
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;
  logic              we_q;
  logic              re_q;
  logic [ERR_W-1:0]  cause_q;
  logic              ready_q;
  logic              err_q;
  logic              busy_q;
  logic [DATA_W-1:0] rdata_q;

  logic              idle;
  logic              req;
  logic              accept;
  logic              enter_resp;
  logic [ERR_W-1:0]  req_cause;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [NB-1:0]     cur_be;
  logic              cur_we;
  logic              cur_re;
  logic [ERR_W-1:0]  cur_cause;
  logic [ERR_W-1:0]  perr_cause;
  logic [ERR_W-1:0]  fin_cause;
  logic [IDX_W-1:0]  cur_idx;
  logic              arr_wr;
  logic              ld_ok;
  logic [DATA_W-1:0] arr_rdata;

  function automatic logic [ERR_W-1:0] classify(
    input logic [ADDR_W-1:0] a,
    input logic              we,
    input logic              re
  );
    logic [ERR_W-1:0] c;
    c = ERR_NONE;
    if (we && re) c = c | ERR_CONFLICT;
    if ((a & OFF_MASK) != '0) c = c | ERR_MISALIGN;
    if ((a >> (OFF_W + IDX_W)) != '0) c = c | ERR_RANGE;
    return c;
  endfunction

  assign idle      = (state_q == S_IDLE);
  assign req       = mem_we | mem_re;
  assign accept    = idle & req;
  assign req_cause = classify(mem_addr, mem_we, mem_re);

  // with zero wait states the accept edge is also the commit edge,
  // so the live bus feeds the array instead of the latch
  always_comb begin
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    cur_we    = we_q;
    cur_re    = re_q;
    cur_cause = cause_q;
    if (idle) begin
      cur_addr  = mem_addr;
      cur_wdata = mem_wdata;
      cur_be    = mem_be;
      cur_we    = mem_we;
      cur_re    = mem_re;
      cur_cause = req_cause;
    end
  end

  assign cur_idx    = IDX_W'(cur_addr >> OFF_W);
  assign enter_resp = (accept && (WAIT_STATES == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd0));
  assign arr_wr     = enter_resp & cur_we & (cur_cause == ERR_NONE);
  assign ld_ok      = cur_re & (cur_cause == ERR_NONE);

`ifdef DMEM_PARITY_EN
  logic arr_perr;

  assign perr_cause = (ld_ok && arr_perr) ? ERR_PARITY : ERR_NONE;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .wr_en_i (arr_wr),
    .idx_i   (cur_idx),
    .wdata_i (cur_wdata),
    .be_i    (cur_be),
    .perr_o  (arr_perr),
    .rdata_o (arr_rdata)
  );
`else
  assign perr_cause = ERR_NONE;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .wr_en_i (arr_wr),
    .idx_i   (cur_idx),
    .wdata_i (cur_wdata),
    .be_i    (cur_be),
    .rdata_o (arr_rdata)
  );
`endif

  assign fin_cause = cur_cause | perr_cause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      cause_q <= ERR_NONE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      if (enter_resp) begin
        ready_q <= 1'b1;
        err_q   <= (fin_cause != ERR_NONE);
        rdata_q <= ld_ok ? arr_rdata : '0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            be_q    <= mem_be;
            we_q    <= mem_we;
            re_q    <= mem_re;
            cause_q <= req_cause;
            cnt_q   <= WS_LOAD;
            busy_q  <= 1'b1;
            state_q <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_RESP;
          else cnt_q <= cnt_q - 4'd1;
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cpu_dmem_ctrl.sv
// Bench for cpu_dmem_ctrl: two instances (0 and 3 wait states) checked every
// cycle against a transaction-level model, plus literal expectations.
module tb_cpu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        we    [2];
  logic        re    [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        err   [2];
  logic        bsy   [2];

  always #5 clk = ~clk;

  cpu_dmem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .mem_be(be[0]), .mem_we(we[0]), .mem_re(re[0]), .mem_rdata(rdata[0]),
    .mem_ready(rdy[0]), .mem_err(err[0]), .busy(bsy[0])
  );

  cpu_dmem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .mem_be(be[1]), .mem_we(we[1]), .mem_re(re[1]), .mem_rdata(rdata[1]),
    .mem_ready(rdy[1]), .mem_err(err[1]), .busy(bsy[1])
  );

  typedef struct {
    int unsigned rc;
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  b;
  } pend_t;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic        pv      [2];
  pend_t       pp      [2];
  int unsigned free_at [2];
  int unsigned acc_cyc [2];
  logic [31:0] mm      [2][256];
  logic        inj     [2][256];

  logic [31:0] cap_rdata [2];
  logic        cap_err   [2];
  int unsigned cap_cyc   [2];
  int          rdy_cnt   [2];
  int          busy_cnt  [2];

  function automatic int unsigned ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and per-cycle compare, sampled 1 time unit after each rising edge
  initial begin
    logic        e_rdy, e_busy, e_err;
    logic [31:0] e_rd;
    logic [7:0]  ix;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      for (int d = 0; d < 2; d++) begin
        e_rdy  = pv[d] && (pp[d].rc == cyc);
        e_busy = pv[d] && (cyc + ws(d) >= pp[d].rc) && (cyc <= pp[d].rc);
        chk($sformatf("ready%0d", d), {31'd0, rdy[d]}, {31'd0, e_rdy});
        chk($sformatf("busy%0d", d), {31'd0, bsy[d]}, {31'd0, e_busy});
        if (rdy[d] === 1'b1) begin
          rdy_cnt[d]++;
          cap_rdata[d] = rdata[d];
          cap_err[d]   = err[d];
          cap_cyc[d]   = cyc;
        end
        if (bsy[d] === 1'b1) busy_cnt[d]++;
        if (e_rdy) begin
          ix    = pp[d].a[9:2];
          e_err = (pp[d].we && pp[d].re) || (pp[d].a[1:0] != 2'b00) ||
                  (pp[d].a[31:10] != 22'd0);
          e_rd  = 32'd0;
          if (!e_err && pp[d].we) begin
            for (int l = 0; l < 4; l++)
              if (pp[d].b[l]) mm[d][ix][8*l +: 8] = pp[d].wd[8*l +: 8];
          end
          if (!e_err && pp[d].re) begin
            e_rd  = mm[d][ix];
            e_err = inj[d][ix];
          end
          chk($sformatf("err%0d", d), {31'd0, err[d]}, {31'd0, e_err});
          chk($sformatf("rdata%0d", d), rdata[d], e_rd);
          pv[d] = 1'b0;
        end
      end
    end
  end

  // drive one request for a single cycle, then scramble the bus
  task automatic access(input int d, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b);
    int unsigned k;
    @(negedge clk);
    we[d] = w; re[d] = r; addr[d] = a; wdata[d] = wd; be[d] = b;
    k = cyc + 1;
    if (k >= free_at[d]) begin
      pv[d]      = 1'b1;
      pp[d]      = '{rc: k + ws(d), we: w, re: r, a: a, wd: wd, b: b};
      free_at[d] = k + ws(d) + 2;
      acc_cyc[d] = k;
    end
    @(negedge clk);
    we[d] = 1'b0; re[d] = 1'b0;
    addr[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom);
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while ((pv[d] || (cyc + 1 < free_at[d])) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL timeout%0d: got no completion expected completion", d);
    end
  endtask

  task automatic load_chk(input int d, input string nm, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
    access(d, 1'b0, 1'b1, a, 32'h0, 4'hF);
    wait_done(d);
    chk({nm, "_rdata"}, cap_rdata[d], exp_d);
    chk({nm, "_err"}, {31'd0, cap_err[d]}, {31'd0, exp_e});
  endtask

  initial begin
    int r0, b0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; we[d] = 1'b0; re[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; be[d] = '0;
      pv[d] = 1'b0; free_at[d] = 0; acc_cyc[d] = 0;
      rdy_cnt[d] = 0; busy_cnt[d] = 0;
      cap_rdata[d] = '0; cap_err[d] = 1'b0; cap_cyc[d] = 0;
      for (int i = 0; i < 256; i++) begin
        mm[d][i] = '0; inj[d][i] = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'd0, rdy[d]}, 32'd0);
      chk("rst_err", {31'd0, err[d]}, 32'd0);
      chk("rst_busy", {31'd0, bsy[d]}, 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;

    // zero wait states: store then load, ready in the cycle after accept
    access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_done(0);
    chk("t1_st_lat", cap_cyc[0] - acc_cyc[0], 32'd0);
    chk("t1_st_err", {31'd0, cap_err[0]}, 32'd0);
    load_chk(0, "t1_ld", 32'h10, 32'hDEADBEEF, 1'b0);
    chk("t1_ld_lat", cap_cyc[0] - acc_cyc[0], 32'd0);
    chk("t1_model", mm[0][4], 32'hDEADBEEF);

    // byte lanes
    access(0, 1'b1, 1'b0, 32'h8, 32'h11223344, 4'hF);
    wait_done(0);
    access(0, 1'b1, 1'b0, 32'h8, 32'hAABBCCDD, 4'b0101);
    wait_done(0);
    load_chk(0, "t3_ld", 32'h8, 32'h11BB33DD, 1'b0);
    chk("t3_model", mm[0][2], 32'h11BB33DD);
    access(0, 1'b1, 1'b0, 32'h8, 32'hFFFFFFFF, 4'h0);
    wait_done(0);
    chk("t3_be0_err", {31'd0, cap_err[0]}, 32'd0);
    load_chk(0, "t3_be0_ld", 32'h8, 32'h11BB33DD, 1'b0);

    // error cases leave word 0 untouched
    access(0, 1'b1, 1'b0, 32'h0, 32'hCAFEF00D, 4'hF);
    wait_done(0);
    load_chk(0, "t4_mis", 32'h402, 32'h0, 1'b1);
    access(0, 1'b1, 1'b0, 32'h400, 32'h12345678, 4'hF);
    wait_done(0);
    chk("t4_oor_err", {31'd0, cap_err[0]}, 32'd1);
    chk("t4_oor_rdata", cap_rdata[0], 32'd0);
    access(0, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF);
    wait_done(0);
    chk("t4_conf_err", {31'd0, cap_err[0]}, 32'd1);
    chk("t4_conf_rdata", cap_rdata[0], 32'd0);
    load_chk(0, "t4_word0", 32'h0, 32'hCAFEF00D, 1'b0);

    // three wait states, request during busy must be dropped
    access(1, 1'b1, 1'b0, 32'h0, 32'h01020304, 4'hF);
    wait_done(1);
    r0 = rdy_cnt[1]; b0 = busy_cnt[1];
    access(1, 1'b0, 1'b1, 32'h0, 32'h0, 4'hF);
    access(1, 1'b1, 1'b0, 32'h0, 32'h00000BAD, 4'hF);
    wait_done(1);
    repeat (3) @(negedge clk);
    chk("t2_lat", cap_cyc[1] - acc_cyc[1], 32'd3);
    chk("t2_busy_cycles", 32'(busy_cnt[1] - b0), 32'd4);
    chk("t2_ready_pulses", 32'(rdy_cnt[1] - r0), 32'd1);
    chk("t2_rdata", cap_rdata[1], 32'h01020304);
    load_chk(1, "t2_word0", 32'h0, 32'h01020304, 1'b0);

    // reset during the first wait cycle of a store
    access(1, 1'b1, 1'b0, 32'h4, 32'h12345678, 4'hF);
    wait_done(1);
    r0 = rdy_cnt[1];
    access(1, 1'b1, 1'b0, 32'h4, 32'h00000055, 4'hF);
    rst[1] = 1'b1; pv[1] = 1'b0; free_at[1] = 0;
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_no_ready", 32'(rdy_cnt[1] - r0), 32'd0);
    chk("t5_busy", {31'd0, bsy[1]}, 32'd0);
    load_chk(1, "t5_word1", 32'h4, 32'h12345678, 1'b0);

`ifdef DMEM_PARITY_EN
    access(0, 1'b1, 1'b0, 32'hC, 32'h0F0F0F0F, 4'hF);
    wait_done(0);
    @(negedge clk);
    u_ws0.u_array.par_q[2][0] = ~u_ws0.u_array.par_q[2][0];
    inj[0][2] = 1'b1;
    load_chk(0, "t6_bad", 32'h8, 32'h11BB33DD, 1'b1);
    load_chk(0, "t6_clean", 32'hC, 32'h0F0F0F0F, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
